// File: rtl/artemis_gtp_bringup_ctrl.sv
// artemis_gtp_bringup_ctrl
// Reset/bring-up sequencer for one GTP lane of the Artemis transceiver tile.
// Holds the transceiver in reset, waits (with timeouts) for PLL detect,
// reset-done and DCM lock, pulses the RX datapath reset, then reports ready.
// Timeouts retry up to MAX_RETRIES times before latching fail; a lock loss
// while ready restarts the sequence without consuming a retry.
// Optional build macro ARTEMIS_GTP_BRINGUP_DEBOUNCE_EN: lock inputs must be
// stable for LOCK_STABLE_CYCLES cycles before advancing, and a lock loss in
// READY must persist for 4 cycles before the sequence restarts.
module artemis_gtp_bringup_ctrl #(
   parameter int RESET_CYCLES       = 16,
   parameter int RX_RESET_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES     = 65536,
   parameter int MAX_RETRIES        = 3,
   parameter int LOCK_STABLE_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_enable,
   input  logic       i_pll_detect,
   input  logic       i_reset_done,
   input  logic       i_dcm_locked,
   output logic       o_gtp_reset,
   output logic       o_rx_reset,
   output logic       o_ready,
   output logic       o_fail,
   output logic [3:0] o_retry_count,
   output logic [2:0] o_state
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RESET_HOLD = 3'd1,
      ST_WAIT_PLL   = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_WAIT_DCM   = 3'd4,
      ST_RX_RST     = 3'd5,
      ST_READY      = 3'd6,
      ST_FAIL       = 3'd7
   } state_t;

   // Shared down-counter must hold the largest load value.
   localparam int CNT_MAX_A = (RESET_CYCLES > RX_RESET_CYCLES) ? RESET_CYCLES : RX_RESET_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   // Number of consecutive qualifying cycles needed to advance on a lock
   // (LOCK_HITS) or to restart on a lock loss in READY (LOSS_HITS).
`ifdef ARTEMIS_GTP_BRINGUP_DEBOUNCE_EN
   localparam int LOCK_HITS = LOCK_STABLE_CYCLES;
   localparam int LOSS_HITS = 4;
`else
   localparam int LOCK_HITS = 1;
   localparam int LOSS_HITS = 1;
`endif
   localparam int STAB_MAX = (LOCK_STABLE_CYCLES > 4) ? LOCK_STABLE_CYCLES : 4;
   localparam int STAB_W   = $clog2(STAB_MAX + 1);

   logic [2:0]        sync1_reg;
   logic [2:0]        sync2_reg;
   logic              pll_s;
   logic              done_s;
   logic              dcm_s;
   logic              loss_s;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [3:0]        retry_reg, retry_next;
   logic [STAB_W-1:0] stab_reg, stab_next;
   logic              gtp_reset_reg, gtp_reset_next;
   logic              rx_reset_reg, rx_reset_next;
   logic              ready_reg, ready_next;
   logic              fail_reg, fail_next;

   logic              retry_req;
   logic              lock_hit;
   logic              loss_hit;
   logic              stab_qual;

   // Two-flop synchronisers for the asynchronous status inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= {i_dcm_locked, i_reset_done, i_pll_detect};
         sync2_reg <= sync1_reg;
      end
   end

   assign pll_s  = sync2_reg[0];
   assign done_s = sync2_reg[1];
   assign dcm_s  = sync2_reg[2];
   assign loss_s = ~pll_s | ~dcm_s;

   assign lock_hit = (stab_reg == STAB_W'(LOCK_HITS - 1));
   assign loss_hit = (stab_reg == STAB_W'(LOSS_HITS - 1));

   // State register, shared counter, retry count and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         retry_reg     <= '0;
         stab_reg      <= '0;
         gtp_reset_reg <= 1'b1;
         rx_reset_reg  <= 1'b1;
         ready_reg     <= 1'b0;
         fail_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         retry_reg     <= retry_next;
         stab_reg      <= stab_next;
         gtp_reset_reg <= gtp_reset_next;
         rx_reset_reg  <= rx_reset_next;
         ready_reg     <= ready_next;
         fail_reg      <= fail_next;
      end
   end

   // Next-state logic; outputs are decoded from the next state so they
   // change on the same edge as the state register.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      retry_next = retry_reg;
      retry_req  = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (i_enable) begin
               state_next = ST_RESET_HOLD;
               cnt_next   = CNT_W'(RESET_CYCLES);
            end
         end
         ST_RESET_HOLD: begin
            if (cnt_reg <= CNT_W'(1)) begin
               state_next = ST_WAIT_PLL;
               cnt_next   = CNT_W'(TIMEOUT_CYCLES);
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_WAIT_PLL: begin
            if (pll_s && lock_hit) begin
               state_next = ST_WAIT_DONE;
               cnt_next   = CNT_W'(TIMEOUT_CYCLES);
            end else if (cnt_reg <= CNT_W'(1)) begin
               retry_req = 1'b1;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (done_s) begin
               state_next = ST_WAIT_DCM;
               cnt_next   = CNT_W'(TIMEOUT_CYCLES);
            end else if (cnt_reg <= CNT_W'(1)) begin
               retry_req = 1'b1;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_WAIT_DCM: begin
            if (dcm_s && lock_hit) begin
               state_next = ST_RX_RST;
               cnt_next   = CNT_W'(RX_RESET_CYCLES);
            end else if (cnt_reg <= CNT_W'(1)) begin
               retry_req = 1'b1;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_RX_RST: begin
            if (cnt_reg <= CNT_W'(1)) begin
               state_next = ST_READY;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_READY: begin
            // Lock-loss restart deliberately leaves the retry count alone.
            if (loss_s && loss_hit) begin
               state_next = ST_RESET_HOLD;
               cnt_next   = CNT_W'(RESET_CYCLES);
            end
         end
         ST_FAIL: begin
            state_next = ST_FAIL;
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase

      if (retry_req) begin
         if (retry_reg < 4'(MAX_RETRIES)) begin
            retry_next = retry_reg + 4'd1;
            state_next = ST_RESET_HOLD;
            cnt_next   = CNT_W'(RESET_CYCLES);
         end else begin
            state_next = ST_FAIL;
            cnt_next   = '0;
         end
      end

      // Dropping enable wins over everything and starts a fresh session.
      if (!i_enable) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
         retry_next = '0;
      end

      gtp_reset_next = (state_next == ST_IDLE) || (state_next == ST_RESET_HOLD) ||
                       (state_next == ST_FAIL);
      rx_reset_next  = (state_next != ST_READY);
      ready_next     = (state_next == ST_READY);
      fail_next      = (state_next == ST_FAIL);
   end

   // Consecutive-cycle counter for lock stability / lock-loss persistence;
   // cleared on every state change or when the watched condition drops.
   always_comb begin
      stab_qual = 1'b0;
      case (state_reg)
         ST_WAIT_PLL: stab_qual = pll_s;
         ST_WAIT_DCM: stab_qual = dcm_s;
         ST_READY:    stab_qual = loss_s;
         default:     stab_qual = 1'b0;
      endcase

      if ((state_next != state_reg) || !stab_qual) begin
         stab_next = '0;
      end else if (stab_reg != STAB_W'(STAB_MAX)) begin
         stab_next = stab_reg + STAB_W'(1);
      end else begin
         stab_next = stab_reg;
      end
   end

   assign o_gtp_reset   = gtp_reset_reg;
   assign o_rx_reset    = rx_reset_reg;
   assign o_ready       = ready_reg;
   assign o_fail        = fail_reg;
   assign o_retry_count = retry_reg;
   assign o_state       = state_reg;

endmodule
